// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel clock-enable generator.
// Each channel counts cycles up to a run-time programmable divide value and
// emits a one-cycle tick plus a 50 % square wave, all in the clk domain.
// A new divide value is staged in a per-channel shadow register and only
// reaches the active ratio at a wrap or a synchronous clear, so a running
// period is never cut short or overrun.
module clk_tick_gen #(
  parameter int                CLK_HZ   = 50_000_000,
  parameter int                NCH      = 4,
  parameter int                DIV_W    = 26,
  parameter logic [DIV_W-1:0]  DIV_INIT = DIV_W'(CLK_HZ - 1),
  parameter int                SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             RESETn,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   sync_clr,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_val,
  output logic [NCH-1:0]   tick_out,
  output logic [NCH-1:0]   sq_out,
  output logic [NCH-1:0]   pend
);

  // Per-channel state
  logic [NCH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][DIV_W-1:0] act_q, act_d;
  logic [NCH-1:0][DIV_W-1:0] shd_q, shd_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            tick_q, tick_d;
  logic [NCH-1:0]            sq_q, sq_d;

  // Decoded per-channel events
  logic                      sel_ok_s;
  logic [NCH-1:0]            wr_hit_s;
  logic [NCH-1:0]            wrap_s;
  logic [NCH-1:0]            apply_s;

  // Decode the divide-value write strobe; out-of-range indices hit nothing
  always_comb begin
    sel_ok_s = ({1'b0, div_sel} < (SEL_W + 1)'(NCH));
    wr_hit_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (div_wr && sel_ok_s && (div_sel == SEL_W'(i))) begin
        wr_hit_s[i] = 1'b1;
      end else begin
        wr_hit_s[i] = 1'b0;
      end
    end
  end

  // Detect wraps and the points where a pending shadow may be applied
  always_comb begin
    wrap_s  = '0;
    apply_s = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap_s[i]  = ch_en[i] && (cnt_q[i] == act_q[i]);
      apply_s[i] = sync_clr[i] || wrap_s[i];
    end
  end

  // Next-state for counters, outputs, shadow and pending flags
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    tick_d = '0;
    sq_d   = sq_q;
    for (int i = 0; i < NCH; i++) begin
      // counter / output update, clear has highest priority
      if (sync_clr[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        sq_d[i]   = 1'b0;
      end else if (!ch_en[i]) begin
        cnt_d[i]  = cnt_q[i];
        tick_d[i] = 1'b0;
        sq_d[i]   = sq_q[i];
      end else if (wrap_s[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        sq_d[i]   = ~sq_q[i];
      end else begin
        cnt_d[i]  = cnt_q[i] + DIV_W'(1);
        tick_d[i] = 1'b0;
        sq_d[i]   = sq_q[i];
      end

      // a wrap or clear uses the shadow that was pending before this edge
      if (apply_s[i] && pend_q[i]) begin
        act_d[i] = shd_q[i];
      end else begin
        act_d[i] = act_q[i];
      end

      // a write in the same cycle stays pending for the following wrap/clear
      if (wr_hit_s[i]) begin
        shd_d[i]  = div_val;
        pend_d[i] = 1'b1;
      end else if (apply_s[i]) begin
        shd_d[i]  = shd_q[i];
        pend_d[i] = 1'b0;
      end else begin
        shd_d[i]  = shd_q[i];
        pend_d[i] = pend_q[i];
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q  <= '0;
      act_q  <= {NCH{DIV_INIT}};
      shd_q  <= {NCH{DIV_INIT}};
      pend_q <= '0;
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_out = tick_q;
  assign sq_out   = sq_q;
  assign pend     = pend_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench for clk_tick_gen: the stimulus pushes hand-computed
// per-bit expectations tagged with the rising-edge number they apply to;
// a monitor compares them shortly after each rising edge.
module tb_clk_tick_gen;

  localparam int NCH   = 4;
  localparam int DIV_W = 8;
  localparam int SEL_W = 2;

  logic             clk;
  logic             RESETn;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   sync_clr;
  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [DIV_W-1:0] div_val;
  logic [NCH-1:0]   tick_out;
  logic [NCH-1:0]   sq_out;
  logic [NCH-1:0]   pend;

  clk_tick_gen #(
    .CLK_HZ   (4),
    .NCH      (NCH),
    .DIV_W    (DIV_W),
    .DIV_INIT (8'd3),
    .SEL_W    (SEL_W)
  ) dut (
    .clk      (clk),
    .RESETn   (RESETn),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_val  (div_val),
    .tick_out (tick_out),
    .sq_out   (sq_out),
    .pend     (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    int   kind;   // 0 tick_out, 1 sq_out, 2 pend
    int   ch;
    logic v;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void ex(int c, int k, int ch, logic v);
    exp_t e;
    e.cyc = c; e.kind = k; e.ch = ch; e.v = v;
    sb.push_back(e);
  endfunction

  function automatic string kname(int k);
    case (k)
      0:       return "tick_out";
      1:       return "sq_out";
      default: return "pend";
    endcase
  endfunction

  function automatic logic actual(int k, int ch);
    case (k)
      0:       return tick_out[ch];
      1:       return sq_out[ch];
      default: return pend[ch];
    endcase
  endfunction

  task automatic chk_vec(string name, logic [NCH-1:0] got, logic [NCH-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // Monitor: count rising edges and compare all expectations due now
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missed %s ch%0d at edge %0d", kname(sb[j].kind), sb[j].ch, sb[j].cyc);
          sb.delete(j);
        end else if (sb[j].cyc == cyc) begin
          n_tests++;
          if (actual(sb[j].kind, sb[j].ch) !== sb[j].v) begin
            n_fail++;
            $display("FAIL %s ch%0d edge %0d: got %b expected %b", kname(sb[j].kind),
                     sb[j].ch, cyc, actual(sb[j].kind, sb[j].ch), sb[j].v);
          end
          sb.delete(j);
        end
      end
    end
  end

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(output int base);
    @(negedge clk);
    RESETn   = 1'b0;
    ch_en    = 4'hF;
    sync_clr = 4'h0;
    div_wr   = 1'b0;
    div_sel  = 2'd0;
    div_val  = 8'd0;
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    base   = cyc;
  endtask

  int b;

  initial begin
    RESETn   = 1'b0;
    ch_en    = 4'hF;
    sync_clr = 4'h0;
    div_wr   = 1'b0;
    div_sel  = 2'd0;
    div_val  = 8'd0;

    // reset state while RESETn is held low
    for (int i = 0; i < NCH; i++) begin
      ex(1, 0, i, 1'b0); ex(1, 1, i, 1'b0); ex(2, 2, i, 1'b0);
    end

    // 1: div=3 from reset, ticks after edges 4, 8, 12
    do_reset(b);
    for (int i = 0; i < NCH; i++) begin
      ex(b+3, 0, i, 1'b0); ex(b+4, 0, i, 1'b1); ex(b+5, 0, i, 1'b0);
      ex(b+8, 0, i, 1'b1); ex(b+12, 0, i, 1'b1);
      ex(b+4, 1, i, 1'b1); ex(b+8, 1, i, 1'b0);
    end
    at(b+12);

    // 2: write div=1 to channel 1 mid-period
    do_reset(b);
    ex(b+2, 2, 1, 1'b0); ex(b+3, 2, 1, 1'b1); ex(b+4, 2, 1, 1'b0);
    ex(b+4, 0, 1, 1'b1); ex(b+5, 0, 1, 1'b0); ex(b+6, 0, 1, 1'b1);
    ex(b+7, 0, 1, 1'b0); ex(b+8, 0, 1, 1'b1); ex(b+10, 0, 1, 1'b1);
    ex(b+4, 1, 1, 1'b1); ex(b+6, 1, 1, 1'b0); ex(b+8, 1, 1, 1'b1);
    ex(b+4, 0, 0, 1'b1); ex(b+6, 0, 0, 1'b0); ex(b+8, 0, 0, 1'b1);
    ex(b+6, 0, 2, 1'b0); ex(b+3, 2, 0, 1'b0);
    at(b+2); div_wr = 1'b1; div_sel = 2'd1; div_val = 8'd1;
    at(b+3); div_wr = 1'b0;
    at(b+10);

    // 3: channel 0 at div=4, enable paused at cnt=2 for 5 cycles
    do_reset(b);
    ex(b+1, 2, 0, 1'b1); ex(b+2, 2, 0, 1'b0); ex(b+2, 1, 0, 1'b0);
    for (int k = 3; k <= 11; k++) ex(b+k, 0, 0, 1'b0);
    ex(b+12, 0, 0, 1'b1); ex(b+13, 0, 0, 1'b0); ex(b+16, 0, 0, 1'b0);
    ex(b+17, 0, 0, 1'b1); ex(b+12, 1, 0, 1'b1); ex(b+17, 1, 0, 1'b0);
    ex(b+4, 0, 1, 1'b1);
    div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd4;
    at(b+1); div_wr = 1'b0; sync_clr = 4'b0001;
    at(b+2); sync_clr = 4'b0000;
    at(b+4); ch_en[0] = 1'b0;
    at(b+9); ch_en[0] = 1'b1;
    at(b+17);

    // 4: div=0 written to channel 2 on the same edge as its wrap
    do_reset(b);
    ex(b+3, 2, 2, 1'b0); ex(b+4, 2, 2, 1'b1); ex(b+7, 2, 2, 1'b1); ex(b+8, 2, 2, 1'b0);
    ex(b+4, 0, 2, 1'b1); ex(b+5, 0, 2, 1'b0); ex(b+6, 0, 2, 1'b0); ex(b+7, 0, 2, 1'b0);
    for (int k = 8; k <= 12; k++) ex(b+k, 0, 2, 1'b1);
    ex(b+4, 1, 2, 1'b1); ex(b+7, 1, 2, 1'b1); ex(b+8, 1, 2, 1'b0);
    ex(b+9, 1, 2, 1'b1); ex(b+10, 1, 2, 1'b0); ex(b+11, 1, 2, 1'b1);
    ex(b+8, 0, 0, 1'b1); ex(b+9, 0, 0, 1'b0);
    at(b+3); div_wr = 1'b1; div_sel = 2'd2; div_val = 8'd0;
    at(b+4); div_wr = 1'b0;
    at(b+12);

    // 5: sync_clr on channel 3 with shadow=2 pending
    do_reset(b);
    ex(b+4, 2, 3, 1'b0); ex(b+5, 2, 3, 1'b1); ex(b+6, 2, 3, 1'b0); ex(b+9, 2, 3, 1'b0);
    ex(b+4, 1, 3, 1'b1); ex(b+5, 1, 3, 1'b1); ex(b+6, 1, 3, 1'b0);
    ex(b+9, 1, 3, 1'b1); ex(b+12, 1, 3, 1'b0); ex(b+15, 1, 3, 1'b1);
    ex(b+4, 0, 3, 1'b1); ex(b+6, 0, 3, 1'b0); ex(b+7, 0, 3, 1'b0); ex(b+8, 0, 3, 1'b0);
    ex(b+9, 0, 3, 1'b1); ex(b+10, 0, 3, 1'b0); ex(b+11, 0, 3, 1'b0);
    ex(b+12, 0, 3, 1'b1); ex(b+15, 0, 3, 1'b1); ex(b+8, 0, 2, 1'b1);
    at(b+4); div_wr = 1'b1; div_sel = 2'd3; div_val = 8'd2;
    at(b+5); div_wr = 1'b0; sync_clr = 4'b1000;
    at(b+6); sync_clr = 4'b0000;
    at(b+15);

    // 6: asynchronous reset while a tick is high and a write is pending
    do_reset(b);
    ex(b+4, 0, 0, 1'b1); ex(b+4, 1, 0, 1'b1); ex(b+4, 2, 0, 1'b1);
    at(b+3); div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd1;
    at(b+4); div_wr = 1'b0;
    #1 RESETn = 1'b0;
    #1;
    chk_vec("async_rst tick_out", tick_out, 4'h0);
    chk_vec("async_rst sq_out", sq_out, 4'h0);
    chk_vec("async_rst pend", pend, 4'h0);
    @(negedge clk);
    RESETn = 1'b1;
    b = cyc;
    ex(b+2, 2, 0, 1'b0); ex(b+4, 0, 0, 1'b1); ex(b+6, 0, 0, 1'b0); ex(b+8, 0, 0, 1'b1);
    at(b+8);

    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unchecked %s ch%0d at edge %0d", kname(sb[0].kind), sb[0].ch, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
